ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH_BYTES, default 2, word width in bytes (W = 8*DATA_WIDTH_BYTES).
REQ-002 Parameter: ADDR_BITS, default 16, RAM address width (A).
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_addr  input  2*A  per-port address; port p at bits [p*A +: A]; port 0 = CPU, port 1 = loader/debug.
REQ-006 req_wdata  input  2*W  per-port write data, same packing.
REQ-007 req_start_read  input  2  per-port one-cycle read request pulse.
REQ-008 req_start_write  input  2  per-port one-cycle write request pulse.
REQ-009 req_rdata  output  2*W  per-port registered read data.
REQ-010 req_busy  output  2  per-port request pending or in flight.
REQ-011 req_overrun  output  2  per-port sticky flag: request dropped.
REQ-012 mem_addr, mem_wdata  output  A, W  to spi_ram_controller addr_in/data_in.
REQ-013 mem_start_read, mem_start_write  output  1, 1  one-cycle start pulses to the controller.
REQ-014 mem_rdata, mem_busy  input  W, 1  controller data_out/busy.
REQ-015 grant  output  2  one-hot owner of the controller; 0 when idle.

Function
REQ-016 Pulse on req_start_* while req_busy[p]=0 SHALL latch addr, wdata and op into port p's pending slot; req_busy[p] SHALL be 1 from the next cycle.
REQ-017 Read and write pulsed together on one port SHALL latch a write; the read is dropped and req_overrun[p] set.
REQ-018 Pulse while req_busy[p]=1 SHALL be ignored and SHALL set req_overrun[p]; the in-flight request is unaffected.
REQ-019 States: IDLE, ISSUE, SETTLE, WAIT.
REQ-020 IDLE: a pending slot moves to ISSUE next cycle, grant set to the winner; no pending stays IDLE, grant=0.
REQ-021 ISSUE (one cycle): drive mem_addr/mem_wdata from the granted slot, assert exactly one of mem_start_read/mem_start_write; go to SETTLE.
REQ-022 SETTLE (one cycle): mem_busy ignored; go to WAIT.
REQ-023 WAIT: hold mem_addr/mem_wdata; on mem_busy=0, for a read copy mem_rdata into req_rdata[p], clear slot p, return to IDLE; req_busy[p] drops the following cycle.
REQ-024 Latency: pulse at T, ISSUE at T+2, earliest completion cycle T+4, req_busy low at T+5 on an idle arbiter.
REQ-025 Arbitration (default): fixed priority, port 0 wins on simultaneous pending.
REQ-026 mem_start_* SHALL never be asserted outside ISSUE; at most one grant bit set; no preemption of an in-flight transfer.
REQ-027 req_rdata[p] SHALL hold its value until the next completed read on port p; writes do not alter it.
REQ-028 req_overrun[p] clears only on reset.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, clear slots, grant=0, req_busy=0, req_overrun=0, req_rdata=0, mem_start_*=0, mem_addr=0, mem_wdata=0, even mid-transfer.
REQ-030 First request is accepted on the first clock edge after rst_n rises.

Configuration
REQ-031 Macro RAM_ARB_ROUND_ROBIN_EN defined: on simultaneous pending, the port not granted last wins (last-grant register resets to port 1, so port 0 wins first tie).
REQ-032 Macro undefined: fixed priority per REQ-025; no last-grant register.

Structure
REQ-033 Package ram_arb_pkg: state enum, port index constants (PORT_CPU=0, PORT_AUX=1), NUM_PORTS=2.
REQ-034 Sub-module ram_arb_port: one pending slot (op, addr, wdata, valid, overrun), instantiated per port.

Verification
REQ-035 Port 0 read 0x0010, controller returns 0xBEEF after 8 busy cycles -> ISSUE at T+2, req_rdata[0]=0xBEEF, req_busy[0] low one cycle after mem_busy falls.
REQ-036 Port 0 write 0x1234 to 0x0020 and port 1 read 0x0030 same cycle -> write issued first, read issued IDLE+1 after write completes, grant sequence 01,00,10.
REQ-037 Port 1 pulses twice while busy -> second ignored, req_overrun=2'b10, first completes normally.
REQ-038 Both start bits on port 0 with addr 0x0040 -> only mem_start_write pulses, req_overrun[0]=1.
REQ-039 rst_n low during WAIT -> all outputs zero same cycle, new request after release completes normally.
REQ-040 With RAM_ARB_ROUND_ROBIN_EN, both ports request continuously for 4 transfers -> grant order 0,1,0,1; without it -> 0,0,0,0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding and port constants for the RAM arbiter
package ram_arb_pkg;
  localparam int NUM_PORTS = 2;
  localparam int PORT_CPU = 0;
  localparam int PORT_AUX = 1;
  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT} state_t;
endpackage

// File: rtl/ram_arb_port.sv
// ram_arb_port: one request slot (op, addr, wdata, valid, sticky overrun) plus its read-data register
module ram_arb_port #(
  parameter int W = 16,
  parameter int A = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_read,
  input  logic         start_write,
  input  logic [A-1:0] addr,
  input  logic [W-1:0] wdata,
  input  logic         done,
  input  logic [W-1:0] mem_rdata,
  output logic         valid,
  output logic         op_write,
  output logic [A-1:0] slot_addr,
  output logic [W-1:0] slot_wdata,
  output logic         overrun,
  output logic [W-1:0] rdata
);
  // latch a request when free, drop it when busy, release the slot when the arbiter finishes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      op_write   <= 1'b0;
      slot_addr  <= '0;
      slot_wdata <= '0;
      overrun    <= 1'b0;
      rdata      <= '0;
    end else begin
      if (done) begin
        valid <= 1'b0;
        if (!op_write) rdata <= mem_rdata;
      end else if (!valid && (start_read || start_write)) begin
        valid      <= 1'b1;
        op_write   <= start_write;
        slot_addr  <= addr;
        slot_wdata <= wdata;
      end
      if ((valid && (start_read || start_write)) || (start_read && start_write)) overrun <= 1'b1;
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port front end for an SPI RAM controller; define RAM_ARB_ROUND_ROBIN_EN for round-robin ties
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH_BYTES = 2,
  parameter int ADDR_BITS = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [2*ADDR_BITS-1:0]          req_addr,
  input  logic [16*DATA_WIDTH_BYTES-1:0]  req_wdata,
  input  logic [1:0]                      req_start_read,
  input  logic [1:0]                      req_start_write,
  output logic [16*DATA_WIDTH_BYTES-1:0]  req_rdata,
  output logic [1:0]                      req_busy,
  output logic [1:0]                      req_overrun,
  output logic [ADDR_BITS-1:0]            mem_addr,
  output logic [8*DATA_WIDTH_BYTES-1:0]   mem_wdata,
  output logic                            mem_start_read,
  output logic                            mem_start_write,
  input  logic [8*DATA_WIDTH_BYTES-1:0]   mem_rdata,
  input  logic                            mem_busy,
  output logic [1:0]                      grant
);
  localparam int W = 8 * DATA_WIDTH_BYTES;
  localparam int A = ADDR_BITS;
  state_t state;
  logic [NUM_PORTS-1:0] pend, op_w;
  logic [A-1:0] s_addr [NUM_PORTS];
  logic [W-1:0] s_wdata [NUM_PORTS];
  logic win, done;
  assign done = state == WAIT && !mem_busy;
  assign req_busy = pend;
`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last;
  assign win = &pend ? ~last : pend[PORT_AUX] & ~pend[PORT_CPU];
`else
  assign win = ~pend[PORT_CPU];
`endif
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    ram_arb_port #(.W(W), .A(A)) u_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_read (req_start_read[p]),
      .start_write(req_start_write[p]),
      .addr       (req_addr[p*A +: A]),
      .wdata      (req_wdata[p*W +: W]),
      .done       (done & grant[p]),
      .mem_rdata  (mem_rdata),
      .valid      (pend[p]),
      .op_write   (op_w[p]),
      .slot_addr  (s_addr[p]),
      .slot_wdata (s_wdata[p]),
      .overrun    (req_overrun[p]),
      .rdata      (req_rdata[p*W +: W])
    );
  end
  // transfer sequencer: pick a slot, pulse the controller once, skip one settle cycle, wait for not-busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      grant           <= 2'b00;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_start_read  <= 1'b0;
      mem_start_write <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last            <= 1'b1;
`endif
    end else begin
      mem_start_read  <= 1'b0;
      mem_start_write <= 1'b0;
      case (state)
        IDLE: if (|pend) begin
          state           <= ISSUE;
          grant           <= win ? 2'b10 : 2'b01;
          mem_addr        <= s_addr[win];
          mem_wdata       <= s_wdata[win];
          mem_start_write <= op_w[win];
          mem_start_read  <= ~op_w[win];
`ifdef RAM_ARB_ROUND_ROBIN_EN
          last            <= win;
`endif
        end
        ISSUE:  state <= SETTLE;
        SETTLE: state <= WAIT;
        WAIT: if (!mem_busy) begin
          state <= IDLE;
          grant <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random checks of ram_arbiter against a transaction-level model
module tb_ram_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, req_rdata;
  logic [1:0] req_start_read = '0, req_start_write = '0, req_busy, req_overrun, grant;
  logic [15:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic mem_start_read, mem_start_write, mem_busy = 1'b0;
  int checks = 0, errors = 0;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_start_read(req_start_read), .req_start_write(req_start_write),
    .req_rdata(req_rdata), .req_busy(req_busy), .req_overrun(req_overrun),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_start_read(mem_start_read),
    .mem_start_write(mem_start_write), .mem_rdata(mem_rdata), .mem_busy(mem_busy), .grant(grant)
  );

  always #5 clk = ~clk;

  // reference model: slot contents per port, current owner and cycles since its issue
  bit sv[2], sw[2], ov[2];
  logic [15:0] sa[2], sd[2], rd[2];
  int owner, age, cnt, lat;
  logic [1:0] eg;
  bit esr, esw, last;
  logic [15:0] ea, ed;
  logic [15:0] ram [256];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(bit p0, bit p1);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    if (p0 && p1) return last ? 0 : 1;
`endif
    return p0 ? 0 : 1;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      sv[p] = 0; sw[p] = 0; ov[p] = 0; sa[p] = '0; sd[p] = '0; rd[p] = '0;
    end
    owner = -1; age = 0; eg = 2'b00; esr = 0; esw = 0; ea = '0; ed = '0; last = 1; cnt = 0;
    mem_busy = 1'b0;
  endtask

  task automatic check_all();
    chk("grant", grant, eg);
    chk("req_busy", req_busy, {sv[1], sv[0]});
    chk("req_overrun", req_overrun, {ov[1], ov[0]});
    chk("req_rdata", req_rdata, {rd[1], rd[0]});
    chk("mem_start", {mem_start_read, mem_start_write}, {esr, esw});
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
  endtask

  // one clock: advance model and the emulated controller with the values present before the edge
  task automatic cycle();
    bit [1:0] psr, psw;
    logic [31:0] pa, pd;
    bit mb, pesr, pesw, pv[2];
    logic [15:0] mr, pea, ped;
    int w;
    psr = req_start_read; psw = req_start_write; pa = req_addr; pd = req_wdata;
    mb = mem_busy; mr = mem_rdata; pesr = esr; pesw = esw; pea = ea; ped = ed;
    pv = sv;
    @(posedge clk);
    #1;
    esr = 0; esw = 0;
    if (owner >= 0 && age >= 2 && !mb) begin
      if (!sw[owner]) rd[owner] = mr;
      sv[owner] = 0; owner = -1; eg = 2'b00;
    end else if (owner >= 0) age++;
    else if (pv[0] || pv[1]) begin
      w = pick(pv[0], pv[1]);
      owner = w; age = 0; eg = w == 1 ? 2'b10 : 2'b01;
      ea = sa[w]; ed = sd[w]; esw = sw[w]; esr = !sw[w]; last = w[0];
    end
    for (int p = 0; p < 2; p++)
      if (psr[p] || psw[p]) begin
        if (pv[p]) ov[p] = 1;
        else begin
          sv[p] = 1; sw[p] = psw[p]; sa[p] = pa[p*16 +: 16]; sd[p] = pd[p*16 +: 16];
          if (psr[p] && psw[p]) ov[p] = 1;
        end
      end
    if (pesw) begin ram[pea[7:0]] = ped; cnt = lat; mem_rdata = 16'($urandom); end
    else if (pesr) begin cnt = lat; mem_rdata = ram[pea[7:0]]; end
    else if (cnt > 0) cnt--;
    mem_busy = cnt > 0;
    req_start_read = '0; req_start_write = '0;
    check_all();
  endtask

  task automatic run_idle(int maxc, output int n);
    n = 0;
    do begin cycle(); n++; end while (req_busy != 2'b00 && n < maxc);
    if (req_busy != 2'b00) chk("timeout", {62'd0, req_busy}, 64'd0);
  endtask

  initial begin
    int n;
    bit saw_r, saw_w;
    logic [1:0] seq[$];
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
    model_reset();
    lat = 1;
    #12;
    check_all();
    @(negedge clk) rst_n = 1'b1;
    // port 0 read with a slow controller
    ram[8'h10] = 16'hBEEF; lat = 8;
    req_addr[15:0] = 16'h0010; req_start_read = 2'b01;
    run_idle(40, n);
    chk("lat_read", n, 12);
    chk("rdata_beef", req_rdata[15:0], 16'hBEEF);
    // simultaneous write on port 0 and read on port 1
    ram[8'h30] = 16'hA5A5; lat = 2;
    req_addr = {16'h0030, 16'h0020}; req_wdata[15:0] = 16'h1234;
    req_start_write = 2'b01; req_start_read = 2'b10;
    n = 0;
    do begin
      cycle(); n++;
      if (seq.size() == 0 || seq[$] != grant) seq.push_back(grant);
    end while (req_busy != 2'b00 && n < 60);
    chk("seq_len", seq.size(), 5);
    chk("seq1", seq[1], 2'b01);
    chk("seq2", seq[2], 2'b00);
    chk("seq3", seq[3], 2'b10);
    chk("rdata_a5", req_rdata[31:16], 16'hA5A5);
    chk("ram_write", ram[8'h20], 16'h1234);
    // port 1 pulses again while busy
    ram[8'h50] = 16'h7777; lat = 3;
    req_addr[31:16] = 16'h0050; req_start_read = 2'b10;
    cycle();
    req_addr[31:16] = 16'h0060; req_start_read = 2'b10;
    run_idle(40, n);
    chk("ovr_aux", req_overrun, 2'b10);
    chk("rdata_77", req_rdata[31:16], 16'h7777);
    // both start bits on port 0
    req_addr[15:0] = 16'h0040; req_wdata[15:0] = 16'h4242;
    req_start_read = 2'b01; req_start_write = 2'b01;
    saw_r = 0; saw_w = 0; n = 0;
    do begin
      cycle(); n++;
      saw_r |= mem_start_read; saw_w |= mem_start_write;
    end while (req_busy != 2'b00 && n < 40);
    chk("both_w", saw_w, 1);
    chk("both_r", saw_r, 0);
    chk("ovr_both", req_overrun, 2'b11);
    chk("rdata_kept", req_rdata[15:0], 16'hBEEF);
    // asynchronous reset during WAIT
    lat = 8;
    req_addr[15:0] = 16'h0010; req_start_read = 2'b01;
    n = 0;
    do begin cycle(); n++; end while (!(owner >= 0 && age >= 2) && n < 20);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk) rst_n = 1'b1;
    lat = 1;
    req_addr[31:16] = 16'h0050; req_start_read = 2'b10;
    run_idle(20, n);
    chk("post_reset_lat", n, 5);
    chk("post_reset_rd", req_rdata[31:16], 16'h7777);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(0, 5);
      for (int p = 0; p < 2; p++) begin
        req_start_read[p] = $urandom_range(0, 3) == 0;
        req_start_write[p] = $urandom_range(0, 4) == 0;
      end
      req_addr = $urandom; req_wdata = $urandom;
      cycle();
    end
    req_start_read = '0; req_start_write = '0;
    run_idle(40, n);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
